// File: rtl/pll_rstseq_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   - state_t     : sequencer state encoding (2-bit)
//   - DEF_*       : default cycle constants for the sequencer parameters
//   - timer_width : width needed by the sequencer timers for a parameter set
package pll_rstseq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int DEF_PLL_RST_CYCLES      = 16;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_HOLD_CYCLES         = 64;
  localparam int DEF_CNT_W               = 8;

  // One bit more than $clog2 of the largest cycle count, so the timers can
  // hold every terminal value with headroom.
  function automatic int timer_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for level signals crossing into clk.
// Ports:
//   clk - destination clock
//   rst - synchronous active-low reset (0 = reset), output resets to 0
//   d   - asynchronous input
//   q   - synchronised output, two clk cycles of latency
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: both stages use non-blocking assignments so each edge shifts the
  // pipe by exactly one stage; blocking here would collapse it to one flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Reset and lock supervisor for the core PLL, clocked by the board reference.
// Pulses the PLL reset, qualifies the synchronised lock signal, then holds
// the system in reset for a fixed time before releasing it. Lock loss or a
// lock timeout re-runs the whole sequence; soft_rst_req re-runs HOLD only.
// Ports:
//   refclk        - reference clock, sole clock of this block
//   rst           - synchronous active-low reset (0 = reset)
//   pll_locked    - PLL lock output, asynchronous to refclk
//   soft_rst_req  - in RUN, re-enter HOLD without resetting the PLL
//   pll_rst       - active-high PLL reset
//   sys_rst_n     - active-low system reset
//   ready         - PLL locked and system out of reset
//   retry_cnt     - saturating count of lock timeouts
//   lock_loss_cnt - saturating count of lock drops seen in RUN
// Build option: define PLL_RSTSEQ_STATUS_EN to implement the two status
// counters; otherwise both read constant 0 and no counter flops exist.
module pll_reset_sequencer
  import pll_rstseq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int HOLD_CYCLES         = DEF_HOLD_CYCLES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             soft_rst_req,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int TW = timer_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                  LOCK_TIMEOUT_CYCLES, HOLD_CYCLES);

  // Terminal values: a phase of N cycles ends on the edge where the timer
  // reads N-1.
  localparam logic [TW-1:0] PLL_RST_LAST = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST    = TW'(HOLD_CYCLES - 1);

  state_t          state;
  logic   [TW-1:0] timer;
  logic   [TW-1:0] stable;
  logic            locked_s;
  logic            stable_hit;
  logic            timeout_hit;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // This edge would make the stable count reach its target / the timeout
  // counter reach its limit.
  assign stable_hit  = locked_s && (stable == STABLE_LAST);
  assign timeout_hit = (timer == TIMEOUT_LAST);

  // Outputs are written alongside every state change so they always match
  // the state register without a decode stage after the flops.
  always_ff @(posedge refclk) begin
    if (!rst) begin
      state     <= PLL_RST;
      timer     <= '0;
      stable    <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      case (state)
        PLL_RST: begin
          if (timer == PLL_RST_LAST) begin
            state   <= WAIT_LOCK;
            timer   <= '0;
            stable  <= '0;
            pll_rst <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        WAIT_LOCK: begin
          stable <= locked_s ? stable + 1'b1 : '0;
          timer  <= timer + 1'b1;
          // Lock acceptance wins over a timeout landing on the same edge.
          if (stable_hit) begin
            state <= HOLD;
            timer <= '0;
          end else if (timeout_hit) begin
            state   <= PLL_RST;
            timer   <= '0;
            pll_rst <= 1'b1;
          end
        end

        HOLD: begin
          if (!locked_s) begin
            state   <= PLL_RST;
            timer   <= '0;
            pll_rst <= 1'b1;
          end else if (timer == HOLD_LAST) begin
            state     <= RUN;
            sys_rst_n <= 1'b1;
            ready     <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        RUN: begin
          if (!locked_s) begin
            state     <= PLL_RST;
            timer     <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
          end else if (soft_rst_req) begin
            state     <= HOLD;
            timer     <= '0;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
          end
        end

        default: begin
          state     <= PLL_RST;
          timer     <= '0;
          pll_rst   <= 1'b1;
          sys_rst_n <= 1'b0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_RSTSEQ_STATUS_EN
  logic             retry_evt;
  logic             loss_evt;
  logic [CNT_W-1:0] retry_q;
  logic [CNT_W-1:0] loss_q;

  // Same conditions the FSM uses for the WAIT_LOCK timeout and RUN lock drop.
  assign retry_evt = (state == WAIT_LOCK) && !stable_hit && timeout_hit;
  assign loss_evt  = (state == RUN) && !locked_s;

  always_ff @(posedge refclk) begin
    if (!rst) begin
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      if (retry_evt && (retry_q != {CNT_W{1'b1}})) retry_q <= retry_q + 1'b1;
      if (loss_evt  && (loss_q  != {CNT_W{1'b1}})) loss_q  <= loss_q + 1'b1;
    end
  end

  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;
`else
  assign retry_cnt     = '0;
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with the short test-plan
// parameters (4/8/32/5 cycles, 2-bit status counters).
module tb_pll_reset_sequencer;

  localparam int CNT_W = 2;

  logic             refclk = 1'b0;
  logic             rst = 1'b0;
  logic             pll_locked = 1'b0;
  logic             soft_rst_req = 1'b0;
  logic             pll_rst;
  logic             sys_rst_n;
  logic             ready;
  logic [CNT_W-1:0] retry_cnt;
  logic [CNT_W-1:0] lock_loss_cnt;

  int n_total = 0;
  int n_pass  = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .HOLD_CYCLES         (5),
    .CNT_W               (CNT_W)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .soft_rst_req  (soft_rst_req),
    .pll_rst       (pll_rst),
    .sys_rst_n     (sys_rst_n),
    .ready         (ready),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #10 refclk = ~refclk;

  typedef struct {
    logic       rst;
    logic       locked;
    logic [2:0] exp;   // {pll_rst, sys_rst_n, ready}
  } vec_t;

  vec_t vecs[28];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Advance one edge and settle just after it; inputs set before this are
  // what the edge samples.
  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  function automatic int exp_cnt(input int v);
`ifdef PLL_RSTSEQ_STATUS_EN
    return (v > 3) ? 3 : v;
`else
    return 0;
`endif
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0:       return pll_rst;
      1:       return sys_rst_n;
      default: return ready;
    endcase
  endfunction

  // Counts consecutive samples (starting with the current one) where the
  // selected output equals val; leaves the bench on the first other sample.
  task automatic run_length(input int sel, input logic val, output int n,
                            output logic pll_seen);
    n = 0;
    pll_seen = 1'b0;
    while ((sig(sel) === val) && (n < 500)) begin
      n++;
      if (pll_rst) pll_seen = 1'b1;
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pll_locked = 1'b0;
    soft_rst_req = 1'b0;
    repeat (3) step();
    rst = 1'b1;
  endtask

  int   n;
  logic seen;

  initial begin
    // Power-up: rst low for edges 0..2, lock from edge 10. pll_rst is high
    // after edges 2..5, locked_s first sampled at edge 12, HOLD after 19,
    // RUN after 24.
    for (int i = 0; i < 28; i++) begin
      vecs[i].rst    = (i >= 3);
      vecs[i].locked = (i >= 10);
      vecs[i].exp    = {(i <= 5), (i >= 24), (i >= 24)};
    end

    for (int i = 0; i < 28; i++) begin
      rst        = vecs[i].rst;
      pll_locked = vecs[i].locked;
      step();
      check($sformatf("powerup[%0d]", i), int'({pll_rst, sys_rst_n, ready}),
            int'(vecs[i].exp));
    end
    check("powerup_retry", int'(retry_cnt), 0);
    check("powerup_loss", int'(lock_loss_cnt), 0);

    // soft_rst_req pulse in RUN: sys_rst_n low exactly 5 samples, no PLL reset.
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    check("soft_ready_low", int'(ready), 0);
    run_length(1, 1'b0, n, seen);
    check("soft_hold_len", n, 5);
    check("soft_no_pll_rst", int'(seen | pll_rst), 0);
    check("soft_ready_back", int'(ready), 1);
    check("soft_loss", int'(lock_loss_cnt), 0);

    // One-cycle lock drop in RUN: seen by the FSM 2 edges later.
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    check("loss_sys_a0", int'(sys_rst_n), 1);
    step();
    check("loss_sys_a1", int'(sys_rst_n), 1);
    step();
    check("loss_outputs", int'({pll_rst, sys_rst_n, ready}), 3'b100);
    check("loss_cnt1", int'(lock_loss_cnt), exp_cnt(1));
    run_length(0, 1'b1, n, seen);
    check("loss_pll_len", n, 4);
    run_length(2, 1'b0, n, seen);
    check("loss_reseq_len", n, 13);

    // soft_rst_req on the same edge the FSM sees the lock drop: loss wins.
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    step();
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    check("prio_pll_rst", int'(pll_rst), 1);
    check("prio_loss_cnt", int'(lock_loss_cnt), exp_cnt(2));
    run_length(0, 1'b1, n, seen);
    check("prio_pll_len", n, 4);
    run_length(2, 1'b0, n, seen);
    check("prio_reseq_len", n, 13);

    // Reset while in HOLD.
    soft_rst_req = 1'b1;
    step();
    soft_rst_req = 1'b0;
    step();
    check("midhold_in_hold", int'({pll_rst, sys_rst_n}), 2'b00);
    rst = 1'b0;
    step();
    check("midhold_outputs", int'({pll_rst, sys_rst_n, ready}), 3'b100);
    check("midhold_retry", int'(retry_cnt), 0);
    check("midhold_loss", int'(lock_loss_cnt), 0);
    rst = 1'b1;

    // Glitchy lock: 6 cycles high, 1 low, then high; counter restarts.
    do_reset();
    run_length(0, 1'b1, n, seen);
    check("glitch_pll_len", n, 4);
    pll_locked = 1'b1;
    repeat (6) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    run_length(2, 1'b0, n, seen);
    check("glitch_ready_wait", n, 15);
    check("glitch_no_pll_rst", int'(seen), 0);

    // Stable target and timeout reached on the same edge: stable wins.
    do_reset();
    run_length(0, 1'b1, n, seen);
    repeat (22) step();
    pll_locked = 1'b1;
    run_length(2, 1'b0, n, seen);
    check("tie_ready_wait", n, 15);
    check("tie_no_pll_rst", int'(seen | pll_rst), 0);
    check("tie_retry", int'(retry_cnt), 0);

    // Lock never arrives: 4 high / 32 low per attempt, retry_cnt saturates.
    do_reset();
    run_length(0, 1'b1, n, seen);
    check("tmo_first_pll_len", n, 4);
    for (int k = 1; k <= 5; k++) begin
      run_length(0, 1'b0, n, seen);
      check($sformatf("tmo_wait_len[%0d]", k), n, 32);
      check($sformatf("tmo_retry[%0d]", k), int'(retry_cnt), exp_cnt(k));
      check($sformatf("tmo_sys[%0d]", k), int'(sys_rst_n), 0);
      run_length(0, 1'b1, n, seen);
      check($sformatf("tmo_pll_len[%0d]", k), n, 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
